// File: rtl/regfile_pkg.sv
// Shared definitions for the LEGv8 register-file read stage.
//   WIDTH    : data width of one architectural register
//   NREGS    : number of architectural registers
//   ADDR_W   : register index width
//   ZERO_REG : index hard-wired to read zero (XZR)
package regfile_pkg;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned ADDR_W = 5;

    typedef logic [WIDTH-1:0]  xreg_t;
    typedef logic [ADDR_W-1:0] raddr_t;

    localparam raddr_t ZERO_REG = 5'd31;

endpackage

// File: rtl/regfile_read_stage_if.sv
// Bus between decode and the register-file read stage.
//   Request side : rd_en, stall, flush, ra1, ra2
//   Storage view : regs (flattened bank, reg i = regs[i*WIDTH +: WIDTH])
//   Write port   : wr_en, wr_addr, wr_data (same-cycle write, used for bypass)
//   Results      : rd_data1/2, rd_addr1/2, rd_valid (registered, 1-cycle latency)
// master : decode side (drives requests, reads results)
// slave  : read stage
interface regfile_read_stage_if;
    import regfile_pkg::*;

    logic                   rd_en;
    logic                   stall;
    logic                   flush;
    raddr_t                 ra1;
    raddr_t                 ra2;
    logic [NREGS*WIDTH-1:0] regs;
    logic                   wr_en;
    raddr_t                 wr_addr;
    xreg_t                  wr_data;
    xreg_t                  rd_data1;
    xreg_t                  rd_data2;
    raddr_t                 rd_addr1;
    raddr_t                 rd_addr2;
    logic                   rd_valid;

    modport master (
        output rd_en, stall, flush, ra1, ra2, regs, wr_en, wr_addr, wr_data,
        input  rd_data1, rd_data2, rd_addr1, rd_addr2, rd_valid
    );

    modport slave (
        input  rd_en, stall, flush, ra1, ra2, regs, wr_en, wr_addr, wr_data,
        output rd_data1, rd_data2, rd_addr1, rd_addr2, rd_valid
    );

endinterface

// File: rtl/rf_read_mux.sv
// One read port of the register file: 32:1 select, XZR force and write bypass.
// Pure combinational.
//   i_regs    : flattened register bank
//   i_ra      : read address
//   i_wr_en   : same-cycle write enable
//   i_wr_addr : same-cycle write address
//   i_wr_data : same-cycle write data
//   o_data    : selected value
module rf_read_mux
    import regfile_pkg::*;
(
    input  logic [NREGS*WIDTH-1:0] i_regs,
    input  raddr_t                 i_ra,
    input  logic                   i_wr_en,
    input  raddr_t                 i_wr_addr,
    input  xreg_t                  i_wr_data,
    output xreg_t                  o_data
);

    xreg_t w_bank;

    assign w_bank = i_regs[i_ra*WIDTH +: WIDTH];

    // XZR wins over the bypass so a write to X31 can never leak through.
    always_comb begin
        o_data = w_bank;
        if (i_ra == ZERO_REG) begin
            o_data = '0;
        end else if (i_wr_en && (i_wr_addr == i_ra)) begin
            o_data = i_wr_data;
        end
    end

endmodule

// File: rtl/regfile_read_stage.sv
// Read side of the LEGv8 register file, registered into the decode/execute boundary.
// Two rf_read_mux ports feed enable-DFF output registers that support stall (hold)
// and flush (bubble). Latency is one cycle.
//   clk   : clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : regfile_read_stage_if.slave (requests, bank, write port, results)
module regfile_read_stage
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    regfile_read_stage_if.slave   bus
);

    xreg_t  w_sel1;
    xreg_t  w_sel2;
    logic   w_clr;
    logic   w_en;

    xreg_t  r_data1;
    xreg_t  r_data2;
    raddr_t r_addr1;
    raddr_t r_addr2;
    logic   r_valid;

    rf_read_mux u_port1 (
        .i_regs    (bus.regs),
        .i_ra      (bus.ra1),
        .i_wr_en   (bus.wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .o_data    (w_sel1)
    );

    rf_read_mux u_port2 (
        .i_regs    (bus.regs),
        .i_ra      (bus.ra2),
        .i_wr_en   (bus.wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .o_data    (w_sel2)
    );

    // Reset and flush both load a bubble, overriding stall; otherwise stall holds.
    assign w_clr = reset | bus.flush;
    assign w_en  = ~bus.stall | w_clr;

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_valid <= w_clr ? 1'b0 : bus.rd_en;
            r_addr1 <= w_clr ? '0   : bus.ra1;
            r_addr2 <= w_clr ? '0   : bus.ra2;
            r_data1 <= w_clr ? '0   : w_sel1;
            r_data2 <= w_clr ? '0   : w_sel2;
        end
    end

    assign bus.rd_valid = r_valid;
    assign bus.rd_addr1 = r_addr1;
    assign bus.rd_addr2 = r_addr2;
    assign bus.rd_data1 = r_data1;
    assign bus.rd_data2 = r_data2;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed testbench for regfile_read_stage: reset, plain reads, bypass, XZR,
// stall hold, flush bubble, rd_en=0 capture and mid-run reset.
module tb_regfile_read_stage;
    import regfile_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    regfile_read_stage_if bus ();

    regfile_read_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input int idx, input logic [63:0] val);
        bus.regs[idx*WIDTH +: WIDTH] = val;
    endtask

    // Advance one clock and settle past the edge before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [63:0] d1,
                             input logic [63:0] d2);
        check_eq({tag, ".valid"}, {63'd0, bus.rd_valid}, {63'd0, v});
        check_eq({tag, ".addr1"}, {59'd0, bus.rd_addr1}, {59'd0, a1});
        check_eq({tag, ".addr2"}, {59'd0, bus.rd_addr2}, {59'd0, a2});
        check_eq({tag, ".data1"}, bus.rd_data1, d1);
        check_eq({tag, ".data2"}, bus.rd_data2, d2);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b1;
        bus.rd_en   = 1'b1;
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        bus.ra1     = 5'd3;
        bus.ra2     = 5'd0;
        bus.regs    = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        for (int i = 0; i < int'(NREGS); i++) set_reg(i, 64'h1000 + 64'(i));
        set_reg(3, 64'h1111);
        set_reg(4, 64'h2222);

        // Reset held for two cycles with a live request.
        step();
        check_out("rst1", 1'b0, 5'd0, 5'd0, 64'd0, 64'd0);
        step();
        check_out("rst2", 1'b0, 5'd0, 5'd0, 64'd0, 64'd0);
        reset = 1'b0;
        step();
        check_eq("rel.valid", {63'd0, bus.rd_valid}, 64'd1);

        // Plain two-port read.
        bus.ra1 = 5'd3;
        bus.ra2 = 5'd4;
        step();
        check_out("read", 1'b1, 5'd3, 5'd4, 64'h1111, 64'h2222);

        // Bypass hit on both ports, then miss on a different address.
        set_reg(5, 64'hAAAA);
        bus.ra1     = 5'd5;
        bus.ra2     = 5'd5;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd5;
        bus.wr_data = 64'hBEEF;
        step();
        check_out("byp", 1'b1, 5'd5, 5'd5, 64'hBEEF, 64'hBEEF);
        bus.wr_addr = 5'd6;
        step();
        check_eq("bypmiss.data1", bus.rd_data1, 64'hAAAA);
        // Only bit 4 differs: must not alias.
        bus.wr_addr = 5'd21;
        step();
        check_eq("bypalias.data1", bus.rd_data1, 64'hAAAA);

        // XZR wins over the bank value and a write to X31.
        set_reg(31, 64'hFFFF);
        bus.ra1     = 5'd31;
        bus.ra2     = 5'd31;
        bus.wr_addr = 5'd31;
        bus.wr_data = 64'h1234;
        step();
        check_out("xzr", 1'b1, 5'd31, 5'd31, 64'd0, 64'd0);

        // Stall holds across a write to the selected register.
        bus.wr_en = 1'b0;
        bus.ra1   = 5'd3;
        bus.ra2   = 5'd4;
        step();
        check_eq("preStall.data1", bus.rd_data1, 64'h1111);
        bus.stall   = 1'b1;
        bus.ra1     = 5'd5;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 64'h9999;
        set_reg(3, 64'h9999);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("stall", 1'b1, 5'd3, 5'd4, 64'h1111, 64'h2222);
        end
        bus.stall = 1'b0;
        bus.wr_en = 1'b0;
        bus.ra1   = 5'd3;
        step();
        check_eq("unstall.data1", bus.rd_data1, 64'h9999);

        // Flush beats stall.
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step();
        check_out("flush", 1'b0, 5'd0, 5'd0, 64'd0, 64'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        step();
        check_out("postFlush", 1'b1, 5'd3, 5'd4, 64'h9999, 64'h2222);

        // rd_en=0 still captures address and data.
        bus.rd_en = 1'b0;
        bus.ra1   = 5'd7;
        bus.ra2   = 5'd8;
        step();
        check_out("noEn", 1'b0, 5'd7, 5'd8, 64'h1007, 64'h1008);

        // Reset mid-run clears everything, even with stall asserted.
        bus.rd_en = 1'b1;
        bus.stall = 1'b1;
        reset     = 1'b1;
        step();
        check_out("midRst", 1'b0, 5'd0, 5'd0, 64'd0, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
